// File: rtl/nes_pll_region_ctrl_if.sv
// Avalon-MM management port between the region sequencer and the PLL reconfig block.
// Handshake: the master holds mgmt_write, mgmt_address and mgmt_writedata steady
// while mgmt_waitrequest is high; a word is accepted on the clock edge where
// mgmt_write = 1 and mgmt_waitrequest = 0.
interface nes_pll_region_ctrl_if;
  logic [5:0]  mgmt_address;
  logic        mgmt_write;
  logic [31:0] mgmt_writedata;
  logic        mgmt_waitrequest;

  modport master (
    output mgmt_address, mgmt_write, mgmt_writedata,
    input  mgmt_waitrequest
  );

  modport slave (
    input  mgmt_address, mgmt_write, mgmt_writedata,
    output mgmt_waitrequest
  );
endinterface

// File: rtl/nes_pll_region_ctrl.sv
// NTSC/PAL PLL reprogramming sequencer. Writes the per-region reconfig table,
// waits for stable lock and owns the NES core reset.
// Optional feature macro: PLL_LOCK_TIMEOUT_EN (lock timeout with pll_rst pulse + retry).
module nes_pll_region_ctrl #(
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                         clk_74a,
  input  logic                         reset_n,
  input  logic                         region_req,
  input  logic                         pll_locked,
  nes_pll_region_ctrl_if.master        mgmt,
  output logic                         pll_rst,
  output logic                         core_reset_n,
  output logic                         region_active,
  output logic                         busy,
  output logic [2:0]                   state_o
);

  typedef enum logic [2:0] {
    HOLD      = 3'd0,
    WAIT_LOCK = 3'd1,
    RUN       = 3'd2,
    WRITE     = 3'd3,
    BUSY      = 3'd4,
    PLL_RESET = 3'd5
  } state_t;

  // One counter width covers both the stable-lock and the timeout count.
  localparam int MAXC = (LOCK_TIMEOUT_CYCLES > LOCK_STABLE_CYCLES) ?
                        LOCK_TIMEOUT_CYCLES : LOCK_STABLE_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);

  state_t        state_q, state_d;
  logic          lock_meta_q, lock_s_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    idx_q, idx_d;
  logic          target_q, target_d;
  logic          region_active_q, region_active_d;
  logic          start_write;
  logic          mgmt_write_q, mgmt_write_d;
  logic [5:0]    mgmt_address_q, mgmt_address_d;
  logic [31:0]   mgmt_writedata_q, mgmt_writedata_d;
  logic          core_reset_n_q, busy_q;
  logic [37:0]   rom_word;
`ifdef PLL_LOCK_TIMEOUT_EN
  logic [CW-1:0] tot_q, tot_d;
  logic [3:0]    rst_cnt_q, rst_cnt_d;
  logic          pll_rst_q;
`endif

  // Reconfig table: {address, data}. N/M/C words use {odd, bypass, high[7:0], low[7:0]},
  // C words carry the counter select in [22:18], K is the 32-bit fractional M.
  function automatic logic [37:0] rom(input logic pal, input logic [3:0] idx);
    logic [37:0] w;
    w = '0;
    case (idx)
      4'd0: w = {6'd0, 32'h0000_0000};
      4'd1: w = {6'd3, 32'h0001_0000};
      4'd2: w = {6'd4, pal ? 32'h0000_0808 : 32'h0000_0404};
      4'd3: w = {6'd7, pal ? 32'h0CF3_BB36 : 32'h1962_D3B2};
      4'd4: w = {6'd5, pal ? 32'h0000_0707 : 32'h0002_0403};
      4'd5: w = {6'd5, pal ? 32'h0004_1C1C : 32'h0004_0E0E};
      4'd6: w = {6'd5, pal ? 32'h0008_7070 : 32'h0008_3838};
      4'd7: w = {6'd5, pal ? 32'h000C_7070 : 32'h000C_3838};
      4'd8: w = {6'd5, pal ? 32'h0010_0E0E : 32'h0010_0707};
      4'd9: w = {6'd2, 32'h0000_0000};
      default: w = '0;
    endcase
    return w;
  endfunction

  // Next-state, counters and registered-output next values.
  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    idx_d           = idx_q;
    target_d        = target_q;
    region_active_d = region_active_q;
    start_write     = 1'b0;
`ifdef PLL_LOCK_TIMEOUT_EN
    tot_d           = tot_q;
    rst_cnt_d       = '0;
`endif
    case (state_q)
      HOLD: begin
        region_active_d = 1'b0;
        state_d         = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (cnt_q == CW'(LOCK_STABLE_CYCLES)) begin
          if (region_req == region_active_q) state_d = RUN;
          else                               start_write = 1'b1;
        end else begin
          cnt_d = lock_s_q ? cnt_q + 1'b1 : '0;
`ifdef PLL_LOCK_TIMEOUT_EN
          tot_d = tot_q + 1'b1;
          if (tot_q == CW'(LOCK_TIMEOUT_CYCLES - 1)) state_d = PLL_RESET;
`endif
        end
      end
      RUN: begin
        if (!lock_s_q)                        state_d = WAIT_LOCK;
        else if (region_req != region_active_q) start_write = 1'b1;
      end
      WRITE: begin
        if (!mgmt.mgmt_waitrequest) begin
          if (idx_q == 4'd9) state_d = BUSY;
          else               idx_d   = idx_q + 4'd1;
        end
      end
      BUSY: begin
        if (!mgmt.mgmt_waitrequest) begin
          region_active_d = target_q;
          state_d         = WAIT_LOCK;
        end
      end
`ifdef PLL_LOCK_TIMEOUT_EN
      PLL_RESET: begin
        rst_cnt_d = rst_cnt_q + 4'd1;
        if (rst_cnt_q == 4'd15) begin
          // Retry programming when the region still disagrees, else just re-wait.
          if (region_req != region_active_q) start_write = 1'b1;
          else                               state_d     = WAIT_LOCK;
        end
      end
`endif
      default: state_d = HOLD;
    endcase
    if (start_write) begin
      state_d  = WRITE;
      target_d = region_req;
      idx_d    = 4'd0;
    end
    if (state_d != WAIT_LOCK) cnt_d = '0;
`ifdef PLL_LOCK_TIMEOUT_EN
    if (state_d != WAIT_LOCK) tot_d = '0;
`endif
    rom_word         = rom(target_d, idx_d);
    mgmt_write_d     = (state_d == WRITE);
    mgmt_address_d   = mgmt_write_d ? rom_word[37:32] : 6'd0;
    mgmt_writedata_d = mgmt_write_d ? rom_word[31:0]  : 32'd0;
  end

  // State, lock synchronizer and registered outputs.
  always_ff @(posedge clk_74a) begin
    if (!reset_n) begin
      state_q          <= HOLD;
      lock_meta_q      <= 1'b0;
      lock_s_q         <= 1'b0;
      cnt_q            <= '0;
      idx_q            <= 4'd0;
      target_q         <= 1'b0;
      region_active_q  <= 1'b0;
      mgmt_write_q     <= 1'b0;
      mgmt_address_q   <= 6'd0;
      mgmt_writedata_q <= 32'd0;
      core_reset_n_q   <= 1'b0;
      busy_q           <= 1'b1;
`ifdef PLL_LOCK_TIMEOUT_EN
      tot_q            <= '0;
      rst_cnt_q        <= 4'd0;
      pll_rst_q        <= 1'b0;
`endif
    end else begin
      state_q          <= state_d;
      lock_meta_q      <= pll_locked;
      lock_s_q         <= lock_meta_q;
      cnt_q            <= cnt_d;
      idx_q            <= idx_d;
      target_q         <= target_d;
      region_active_q  <= region_active_d;
      mgmt_write_q     <= mgmt_write_d;
      mgmt_address_q   <= mgmt_address_d;
      mgmt_writedata_q <= mgmt_writedata_d;
      core_reset_n_q   <= (state_d == RUN);
      busy_q           <= (state_d != RUN);
`ifdef PLL_LOCK_TIMEOUT_EN
      tot_q            <= tot_d;
      rst_cnt_q        <= rst_cnt_d;
      pll_rst_q        <= (state_d == PLL_RESET);
`endif
    end
  end

  assign mgmt.mgmt_write     = mgmt_write_q;
  assign mgmt.mgmt_address   = mgmt_address_q;
  assign mgmt.mgmt_writedata = mgmt_writedata_q;
  assign core_reset_n        = core_reset_n_q;
  assign region_active       = region_active_q;
  assign busy                = busy_q;
  assign state_o             = state_q;
`ifdef PLL_LOCK_TIMEOUT_EN
  assign pll_rst             = pll_rst_q;
`else
  assign pll_rst             = 1'b0;
`endif

endmodule
